// File: rtl/adcsnap_capture_ctrl.sv
`default_nettype none
// ============================================================================
// adcsnap_capture_ctrl: arm / trigger / skip sequencer that writes one ADC
// snapshot of 2**ADDR_W samples into BRAM.               Revision: 1.0
// ============================================================================
module adcsnap_capture_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              OPB_Clk,
    input  logic              OPB_Rst,
    input  logic [31:0]       ctrl,
    input  logic [31:0]       offset,
    input  logic              trig,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic              bram_we,
    output logic [31:0]       status
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_SKIP    = 2'd2,
        S_CAPTURE = 2'd3
    } state_e;

    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};

    state_e            state_q;
    logic              arm_q;
    logic              done_q;
    logic [ADDR_W:0]   count_q;
    logic [31:0]       skip_q;
    logic              bram_we_q;
    logic [ADDR_W-1:0] bram_addr_q;
    logic [DATA_W-1:0] bram_data_q;
    logic [31:0]       status_q;
    logic [31:0]       status_d;

    logic arm_edge;
    logic acc;
    logic trig_any;
    logic unused_ctrl;

    assign arm_edge    = ctrl[0] & ~arm_q;
    assign acc         = din_valid | ctrl[2];
    assign trig_any    = trig | ctrl[1];
    assign unused_ctrl = ^ctrl[31:3];

    // Count sits in the low bits; state/busy/done occupy the top nibble.
    always_comb begin
        status_d           = '0;
        status_d[31]       = done_q;
        status_d[30]       = (state_q != S_IDLE);
        status_d[29:28]    = state_q;
        status_d[ADDR_W:0] = count_q;
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q     <= S_IDLE;
            arm_q       <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            skip_q      <= '0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_data_q <= '0;
            status_q    <= '0;
        end else begin
            arm_q     <= ctrl[0];
            bram_we_q <= 1'b0;
            status_q  <= status_d;

            // A fresh arm edge wins over everything, including a pending write.
            if (arm_edge) begin
                state_q <= S_ARMED;
                count_q <= '0;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                    end
                    S_ARMED: begin
                        if (trig_any) begin
                            skip_q  <= offset;
                            state_q <= (offset == 32'd0) ? S_CAPTURE : S_SKIP;
                        end
                    end
                    S_SKIP: begin
                        if (acc) begin
                            skip_q <= skip_q - 32'd1;
                            if (skip_q == 32'd1) begin
                                state_q <= S_CAPTURE;
                            end
                        end
                    end
                    S_CAPTURE: begin
                        if (acc) begin
                            bram_we_q   <= 1'b1;
                            bram_addr_q <= count_q[ADDR_W-1:0];
                            bram_data_q <= din;
                            count_q     <= count_q + CNT_ONE;
                            if (count_q == CNT_LAST) begin
                                state_q <= S_IDLE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_data = bram_data_q;
    assign status    = status_q;

endmodule
`default_nettype wire

// File: tb/tb_adcsnap_capture_ctrl.sv
`default_nettype none
// ============================================================================
// tb_adcsnap_capture_ctrl: randomized scenario bench with a transaction-level
// model of which accepted samples land at which BRAM address.  Revision: 1.0
// ============================================================================
module tb_adcsnap_capture_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [31:0] ST_ARMED = 32'h5000_0000;
    localparam logic [31:0] ST_DONE  = 32'h8000_0010;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       ctrl = '0;
    logic [31:0]       offset = '0;
    logic              trig = 1'b0;
    logic              din_valid = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              bram_we;
    logic [31:0]       status;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;

    adcsnap_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .OPB_Clk   (clk),
        .OPB_Rst   (rst),
        .ctrl      (ctrl),
        .offset    (offset),
        .trig      (trig),
        .din_valid (din_valid),
        .din       (din),
        .bram_addr (bram_addr),
        .bram_data (bram_data),
        .bram_we   (bram_we),
        .status    (status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bram_we === 1'b1) obs_q.push_back('{cyc, bram_addr, bram_data});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; ctrl = '0; trig = 1'b0; din_valid = 1'b0; din = '0; offset = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic arm(input logic [31:0] c);
        ctrl = c; trig = 1'b0; din_valid = 1'b0;
        step();
    endtask

    // Trigger from ARMED, then feed samples; the model skips `off` accepted
    // samples and expects the next DEPTH accepted ones at addresses 0..DEPTH-1,
    // one cycle after each is presented.
    task automatic capture_phase(input int off, input bit ext, input logic [31:0] base,
                                 input int mode, input int stop_after, output bit stopped);
        int skipped;
        int written;
        int budget;
        bit v;
        bit alt;
        stopped = 1'b0; skipped = 0; written = 0; alt = 1'b1;
        offset = off; trig = ext; ctrl = ext ? base : (base | 32'h2);
        din_valid = 1'($urandom_range(0, 1)); din = $urandom;
        step();
        vectors++;
        if (status !== ST_ARMED) begin
            miscompares++;
            $display("FAIL armed_status: got %h want %h", status, ST_ARMED);
        end
        ctrl = base; trig = 1'b0;
        budget = 4 * DEPTH + 4 * off + 50;
        while (written < DEPTH) begin
            if (written == stop_after) begin
                stopped = 1'b1;
                return;
            end
            if (budget == 0) begin
                vectors++; miscompares++;
                $display("FAIL capture_budget: got %0d writes want %0d", written, DEPTH);
                return;
            end
            case (mode)
                0:       v = 1'($urandom_range(0, 1));
                1:       v = alt;
                2:       v = 1'b1;
                default: v = 1'b0;
            endcase
            alt = ~alt;
            din_valid = v; din = $urandom; offset = $urandom; trig = 1'($urandom_range(0, 1));
            if (v | base[2]) begin
                if (skipped < off) skipped++;
                else begin
                    exp_q.push_back('{cyc + 1, ADDR_W'(written), din});
                    written++;
                end
            end
            step();
            budget--;
        end
        trig = 1'b0;
    endtask

    task automatic compare_writes(input string name);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s_write_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].addr !== exp_q[i].addr ||
                obs_q[i].data !== exp_q[i].data) begin
                miscompares++;
                $display("FAIL %s_write[%0d]: got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                         name, i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data,
                         exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // With ctrl[0] still held the block must stay done and idle.
    task automatic finish_check(input string name);
        for (int i = 0; i < 3; i++) begin
            din_valid = 1'($urandom_range(0, 1)); din = $urandom; trig = 1'($urandom_range(0, 1));
            step();
            vectors++;
            if (status !== ST_DONE) begin
                miscompares++;
                $display("FAIL %s_done_status: got %h want %h", name, status, ST_DONE);
            end
            vectors++;
            if (bram_we !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_idle_we: got %b want 0", name, bram_we);
            end
        end
        compare_writes(name);
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (status !== 32'h0 || bram_we !== 1'b0 || bram_addr !== '0 || bram_data !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got status %h we %b addr %0d data %h want all zero",
                     status, bram_we, bram_addr, bram_data);
        end
        ctrl = 32'h1;
        step();
        vectors++;
        if (status !== 32'h0) begin
            miscompares++;
            $display("FAIL arm_status_lag: got %h want %h", status, 32'h0);
        end
        step();
        vectors++;
        if (status !== ST_ARMED) begin
            miscompares++;
            $display("FAIL arm_status: got %h want %h", status, ST_ARMED);
        end
    endtask

    task automatic test_immediate();
        bit s;
        apply_reset();
        arm(32'h3);
        capture_phase(0, 1'b0, 32'h3, 2, -1, s);
        finish_check("immediate");
    endtask

    task automatic test_offset_trigger();
        bit s;
        apply_reset();
        arm(32'h1);
        capture_phase(5, 1'b1, 32'h1, 1, -1, s);
        finish_check("offset5");
    endtask

    task automatic test_random();
        bit s;
        logic [31:0] base;
        for (int n = 0; n < 6; n++) begin
            apply_reset();
            base = {29'b0, 1'($urandom_range(0, 1)), 2'b01};
            arm(base);
            capture_phase($urandom_range(0, 20), 1'($urandom_range(0, 1)), base, 0, -1, s);
            finish_check("random");
        end
    endtask

    task automatic test_rearm();
        bit s;
        apply_reset();
        arm(32'h1);
        capture_phase($urandom_range(0, 3), 1'b1, 32'h1, 0, 7, s);
        vectors++;
        if (s !== 1'b1) begin
            miscompares++;
            $display("FAIL rearm_reach7: got stopped %b want 1", s);
        end
        ctrl = 32'h0; trig = 1'b0; din_valid = 1'b0;
        step();
        vectors++;
        if (status !== 32'h7000_0007) begin
            miscompares++;
            $display("FAIL rearm_partial_status: got %h want %h", status, 32'h7000_0007);
        end
        ctrl = 32'h1; din_valid = 1'b1; din = $urandom;
        step();
        din_valid = 1'b1; din = $urandom;
        step();
        vectors++;
        if (status !== ST_ARMED) begin
            miscompares++;
            $display("FAIL rearm_status: got %h want %h", status, ST_ARMED);
        end
        capture_phase($urandom_range(0, 3), 1'b0, 32'h1, 0, -1, s);
        finish_check("rearm");
    endtask

    task automatic test_async_reset();
        bit s;
        apply_reset();
        arm(32'h1);
        capture_phase(0, 1'b1, 32'h1, 2, 5, s);
        @(negedge clk);
        #1;
        rst = 1'b1; ctrl = '0; trig = 1'b0; din_valid = 1'b0;
        #1;
        vectors++;
        if (status !== 32'h0 || bram_we !== 1'b0 || bram_addr !== '0 || bram_data !== '0) begin
            miscompares++;
            $display("FAIL async_reset_outputs: got status %h we %b addr %0d data %h want all zero",
                     status, bram_we, bram_addr, bram_data);
        end
        compare_writes("async_rst");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            trig = 1'($urandom_range(0, 1)); din_valid = 1'($urandom_range(0, 1)); din = $urandom;
            step();
        end
        trig = 1'b0;
        vectors++;
        if (obs_q.size() != 0 || status !== 32'h0) begin
            miscompares++;
            $display("FAIL trig_unarmed: got %0d writes status %h want 0 writes status 0",
                     obs_q.size(), status);
        end
        obs_q.delete();
    endtask

    task automatic test_ignore_valid();
        bit s;
        apply_reset();
        arm(32'h5);
        capture_phase($urandom_range(0, 3), 1'b0, 32'h5, 3, -1, s);
        @(negedge clk);
        #1;
        vectors++;
        if (obs_q.size() != DEPTH) begin
            miscompares++;
            $display("FAIL ignore_valid_count: got %0d want %0d", obs_q.size(), DEPTH);
        end else if (obs_q[DEPTH-1].cyc - obs_q[0].cyc != DEPTH - 1) begin
            miscompares++;
            $display("FAIL ignore_valid_span: got %0d want %0d",
                     obs_q[DEPTH-1].cyc - obs_q[0].cyc, DEPTH - 1);
        end
        finish_check("ignore_valid");
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_offset_trigger();
        test_random();
        test_rearm();
        test_async_reset();
        test_ignore_valid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
